snn_input_loader: RTL and testbench
===================================

SNN_INPUT_LOADER -- requirements
Module: snn_input_loader

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter NUM_PIXELS, default 784, meaning the number of 1-bit input units per image.
REQ-003 SHALL have parameter ADDR_W, default 10, meaning the input-unit RAM address width.
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 rx_rdy  input  1  single-cycle pulse: rx_data valid.
REQ-007 rx_data  input  8  received byte, 8 pixels, bit0 = lowest address.
REQ-008 ram_we  output  1  input-unit RAM write enable.
REQ-009 ram_addr  output  ADDR_W  input-unit RAM write address.
REQ-010 ram_data  output  1  pixel bit written.
REQ-011 core_start  output  1  single-cycle pulse starting inference.
REQ-012 core_done  input  1  inference complete; core_digit is valid on that cycle.
REQ-013 core_digit  input  4  classified digit, 0-9.
REQ-014 tx_start  output  1  single-cycle pulse: send tx_data.
REQ-015 tx_data  output  8  ASCII result byte.
REQ-016 tx_busy  input  1  transmitter is occupied.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 overrun  output  1  sticky flag: a received byte was dropped.

Function
REQ-019 SHALL implement the states IDLE, UNPACK, START, WAIT_DONE, TX_WAIT and TX.
REQ-020 IDLE: rx_rdy SHALL load rx_data into the shift register and move to UNPACK on the next cycle.
REQ-021 UNPACK: one bit per cycle, LSB first, with ram_we=1, ram_data=shift[0] and ram_addr=pixel count; count increments each cycle.
REQ-022 Each byte SHALL take exactly 8 UNPACK cycles.
REQ-023 After bit 7, if the buffer is full, the buffer SHALL load into the shift register and UNPACK SHALL continue with no gap cycle.
REQ-024 If the buffer is empty after bit 7, the block SHALL return to IDLE, keeping the count.
REQ-025 rx_rdy during UNPACK SHALL fill a one-deep byte buffer.
REQ-026 rx_rdy while the buffer is already full SHALL drop the byte and set overrun.
REQ-027 rx_rdy on the cycle the buffer drains SHALL be accepted, not dropped.
REQ-028 When the write of address NUM_PIXELS-1 completes, the block SHALL go to START, reset the count to 0 and discard remaining bits of that byte.
REQ-029 NUM_PIXELS multiple of 8 => no bits are discarded (784 = 98 bytes).
REQ-030 START: core_start=1 for exactly one cycle, then WAIT_DONE.
REQ-031 WAIT_DONE: on core_done, the block SHALL latch core_digit and go to TX_WAIT.
REQ-032 core_done outside WAIT_DONE SHALL be ignored.
REQ-033 TX_WAIT: the block SHALL hold while tx_busy=1, then go to TX.
REQ-034 TX: tx_start=1 for one cycle with tx_data=8'h30+digit, then IDLE.
REQ-035 tx_data SHALL hold its value until the next TX.
REQ-036 Latency: core_start SHALL assert exactly 1 cycle after the last pixel write.
REQ-037 Latency: tx_start SHALL assert 2 cycles after core_done when tx_busy=0.
REQ-038 rx_rdy in START, WAIT_DONE, TX_WAIT or TX SHALL drop the byte and set overrun.
REQ-039 overrun SHALL clear only on reset.
REQ-040 ram_we SHALL be 0 in every state except UNPACK.

Reset
REQ-041 Reset SHALL force IDLE and clear the count, the buffer-valid flag and overrun.
REQ-042 Reset SHALL drive ram_we, core_start, tx_start and busy to 0.
REQ-043 Reset SHALL drive ram_addr and ram_data to 0 and tx_data to 8'h00.
REQ-044 Reset asserted mid-image SHALL abandon the partial image; the next byte SHALL write from address 0.

Structure
REQ-045 Package snn_pkg SHALL hold the loader state enum, NUM_PIXELS and the ASCII_ZERO=8'h30 constant.
REQ-046 SHALL be a single module with no sub-module; the byte buffer is inline.

Verification
REQ-047 98 bytes of 8'hA5 with a 20-cycle gap -> 784 writes and core_start once, 1 cycle after the write to 783.
REQ-048 Within each byte, ram_data SHALL read 1,0,1,0,0,1,0,1 on successive addresses.
REQ-049 Two bytes in consecutive cycles during UNPACK -> the first is written, the second is buffered and written back-to-back, overrun=0.
REQ-050 A third back-to-back byte -> dropped, overrun=1.
REQ-051 core_done with core_digit=7 while tx_busy=1 for 10 cycles -> tx_start once, after tx_busy falls, with tx_data=8'h37.
REQ-052 Reset after 50 bytes, then a full image -> the first write is at address 0 and core_start fires after exactly 98 bytes.
REQ-053 rx_rdy during WAIT_DONE -> no RAM write, overrun=1, and the inference result is still transmitted.

Source files
------------

// File: rtl/snn_pkg.sv
// Shared definitions for the SNN input loader: FSM states, image size, ASCII base.
package snn_pkg;

    // Loader FSM states, also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_UNPACK    = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_TX_WAIT   = 3'd4,
        ST_TX        = 3'd5
    } loader_state_t;

    // Number of 1-bit input units per image (28 x 28).
    localparam int NUM_PIXELS = 784;

    // Digit d is reported as the ASCII character '0' + d.
    localparam logic [7:0] ASCII_ZERO = 8'h30;

endpackage

// File: rtl/snn_input_loader.sv
// SNN input loader: unpacks received bytes into the 1-bit input-unit RAM,
// starts inference once a full image is written, then sends the digit as ASCII.
//
// Handshake semantics: rx_rdy, core_done, core_start and tx_start are single-cycle
// pulses with no back-pressure; a byte that arrives when it cannot be held is
// dropped and the sticky overrun flag records it. tx_busy is a level that holds
// the result byte back until the transmitter is free.
module snn_input_loader #(
    parameter int NUM_PIXELS = snn_pkg::NUM_PIXELS,
    parameter int ADDR_W     = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_rdy,
    input  logic [7:0]             rx_data,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic                   ram_data,
    output logic                   core_start,
    input  logic                   core_done,
    input  logic [3:0]             core_digit,
    output logic                   tx_start,
    output logic [7:0]             tx_data,
    input  logic                   tx_busy,
    output logic                   busy,
    output logic                   overrun,
    output snn_pkg::loader_state_t dbg_state
);
    import snn_pkg::*;

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        buf_q, buf_d;
    logic              buf_v_q, buf_v_d;
    logic              ovr_q, ovr_d;
    logic [3:0]        digit_q, digit_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              ram_we_q, core_start_q, tx_start_q, busy_q;
    logic              last_pix, last_bit;

    assign last_pix = (count_q == ADDR_W'(NUM_PIXELS - 1));
    assign last_bit = (bit_q == 3'd7);

    // Next-state, pixel counter, shift register and one-deep byte buffer.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        buf_d     = buf_q;
        buf_v_d   = buf_v_q;
        ovr_d     = ovr_q;
        digit_d   = digit_q;
        tx_data_d = tx_data_q;
        case (state_q)
            ST_IDLE: begin
                if (rx_rdy) begin
                    shift_d = rx_data;
                    bit_d   = 3'd0;
                    state_d = ST_UNPACK;
                end
            end
            ST_UNPACK: begin
                count_d = count_q + ADDR_W'(1);
                shift_d = shift_q >> 1;
                bit_d   = bit_q + 3'd1;
                if (last_pix) begin
                    // Image complete: leftover bits and any byte held for it are dropped.
                    state_d = ST_START;
                    count_d = '0;
                    bit_d   = 3'd0;
                    buf_v_d = 1'b0;
                    if (buf_v_q || rx_rdy) ovr_d = 1'b1;
                end else if (last_bit) begin
                    if (buf_v_q) begin
                        // Buffer drains into the shift register; a byte arriving now refills it.
                        shift_d = buf_q;
                        buf_v_d = rx_rdy;
                        if (rx_rdy) buf_d = rx_data;
                    end else if (rx_rdy) begin
                        // Empty buffer: a byte arriving on the last bit goes straight in.
                        shift_d = rx_data;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (rx_rdy) begin
                    if (buf_v_q) begin
                        ovr_d = 1'b1;
                    end else begin
                        buf_d   = rx_data;
                        buf_v_d = 1'b1;
                    end
                end
            end
            ST_START: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (core_done) begin
                    digit_d = core_digit;
                    state_d = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                if (!tx_busy) begin
                    state_d   = ST_TX;
                    tx_data_d = ASCII_ZERO + {4'h0, digit_q};
                end
            end
            ST_TX: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // No byte can be accepted while an inference or transmission is in flight.
        if (rx_rdy && (state_q != ST_IDLE) && (state_q != ST_UNPACK)) ovr_d = 1'b1;
    end

    // State and datapath registers; strobes are registered from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            bit_q        <= 3'd0;
            shift_q      <= 8'h00;
            buf_q        <= 8'h00;
            buf_v_q      <= 1'b0;
            ovr_q        <= 1'b0;
            digit_q      <= 4'h0;
            tx_data_q    <= 8'h00;
            ram_we_q     <= 1'b0;
            core_start_q <= 1'b0;
            tx_start_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            buf_q        <= buf_d;
            buf_v_q      <= buf_v_d;
            ovr_q        <= ovr_d;
            digit_q      <= digit_d;
            tx_data_q    <= tx_data_d;
            ram_we_q     <= (state_d == ST_UNPACK);
            core_start_q <= (state_d == ST_START);
            tx_start_q   <= (state_d == ST_TX);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign ram_we     = ram_we_q;
    assign ram_addr   = count_q;
    assign ram_data   = shift_q[0];
    assign core_start = core_start_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign overrun    = ovr_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// Self-checking bench for snn_input_loader: a byte-level write scoreboard plus
// directed latency, buffering, overrun and reset scenarios.
module tb_snn_input_loader;
    localparam int NP = 784;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic          ram_data;
    logic          core_start;
    logic          core_done;
    logic [3:0]    core_digit;
    logic          tx_start;
    logic [7:0]    tx_data;
    logic          tx_busy;
    logic          busy;
    logic          overrun;
    snn_pkg::loader_state_t dbg_state;

    snn_input_loader #(.NUM_PIXELS(NP), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
        .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .busy(busy), .overrun(overrun), .dbg_state(dbg_state)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard state
    int n_pass = 0;
    int n_total = 0;
    logic [AW:0] exp_q[$];      // {addr, bit} of every expected RAM write, in order
    logic [7:0]  tx_exp_q[$];   // expected result bytes
    int   pix = 0;              // model pixel counter
    logic exp_ovr = 1'b0;
    logic exp_cs = 1'b0;
    logic check_en = 1'b0;
    int   wr_cnt = 0, cs_cnt = 0, tx_cnt = 0;
    int   last_wr_cyc = 0, cs_cyc = 0, tx_cyc = 0;
    int   seq_cyc = 0, done_cyc = 0, fall_cyc = 0;
    int   first_addr = -1;
    logic wr_bits[NP];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Model: an accepted byte produces 8 writes, LSB first, at consecutive pixel addresses.
    task automatic model_push(input logic [7:0] d);
        for (int b = 0; b < 8; b++) begin
            exp_q.push_back({pix[AW-1:0], d[b]});
            pix = (pix == NP - 1) ? 0 : pix + 1;
        end
    endtask

    // Driver: n bytes on consecutive cycles, the first n_acc expected to be accepted.
    task automatic send_seq(input int n, input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input int n_acc);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (i > 0 && i - 1 >= n_acc) exp_ovr = 1'b1;
            if (i == 0) seq_cyc = cyc;
            d = (i == 0) ? d0 : ((i == 1) ? d1 : d2);
            rx_rdy = 1'b1;
            rx_data = d;
            if (i < n_acc) model_push(d);
        end
        @(posedge clk); #1;
        rx_rdy = 1'b0;
        if (n - 1 >= n_acc) exp_ovr = 1'b1;
    endtask

    // Driver: core_done pulse with a digit, transmitter busy for busy_cycles cycles.
    task automatic do_done(input logic [3:0] digit, input int busy_cycles);
        @(posedge clk); #1;
        core_done = 1'b1;
        core_digit = digit;
        tx_busy = (busy_cycles > 0);
        done_cyc = cyc;
        tx_exp_q.push_back(8'h30 + {4'h0, digit});
        @(posedge clk); #1;
        core_done = 1'b0;
        if (busy_cycles > 0) begin
            repeat (busy_cycles - 1) @(posedge clk);
            #1;
            check("tx_held_while_busy", tx_cnt, 0);
            tx_busy = 1'b0;
            fall_cyc = cyc;
        end
    endtask

    // Compare process: every cycle out of reset
    always @(negedge clk) begin
        if (!rst && check_en) begin
            logic [AW:0] e;
            check("core_start", core_start, exp_cs);
            if (core_start) begin cs_cnt++; cs_cyc = cyc; end
            exp_cs = 1'b0;
            if (ram_we) begin
                if (wr_cnt == 0) first_addr = ram_addr;
                wr_cnt++;
                last_wr_cyc = cyc;
                wr_bits[ram_addr] = ram_data;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", ram_we, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("ram_addr", ram_addr, e[AW:1]);
                    check("ram_data", ram_data, e[0]);
                    if (e[AW:1] == AW'(NP - 1)) exp_cs = 1'b1;
                end
            end
            check("overrun", overrun, exp_ovr);
            if (tx_start) begin
                tx_cnt++;
                tx_cyc = cyc;
                if (tx_exp_q.size() == 0) check("unexpected_tx", tx_start, 1'b0);
                else check("tx_data", tx_data, tx_exp_q.pop_front());
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int wr_before, tx_before;
        rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
        core_done = 1'b0; core_digit = 4'h0; tx_busy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ram_we", ram_we, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_ram_data", ram_data, 0);
        check("rst_core_start", core_start, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        check_en = 1'b1;

        // Full image of 0xA5 bytes with 20-cycle gaps
        wr_cnt = 0; cs_cnt = 0;
        for (int i = 0; i < 98; i++) begin
            send_seq(1, 8'hA5, 8'h00, 8'h00, 1);
            repeat (20) @(posedge clk);
        end
        #1;
        check("img_writes", wr_cnt, 784);
        check("img_core_start_cnt", cs_cnt, 1);
        check("img_cs_latency", cs_cyc, last_wr_cyc + 1);
        pat = 8'hA5;
        check("a5_bit0", wr_bits[0], 1); check("a5_bit1", wr_bits[1], 0);
        check("a5_bit2", wr_bits[2], 1); check("a5_bit3", wr_bits[3], 0);
        check("a5_bit4", wr_bits[4], 0); check("a5_bit5", wr_bits[5], 1);
        check("a5_bit6", wr_bits[6], 0); check("a5_bit7", wr_bits[7], 1);
        check("a5_last_byte_bit7", wr_bits[783], pat[7]);
        check("img_queue_empty", exp_q.size(), 0);
        check("busy_wait_done", busy, 1);
        check("state_wait_done", 32'(dbg_state), 32'(snn_pkg::ST_WAIT_DONE));

        // Result with an idle transmitter
        tx_cnt = 0;
        do_done(4'd3, 0);
        repeat (5) @(posedge clk); #1;
        check("tx3_cnt", tx_cnt, 1);
        check("tx3_latency", tx_cyc, done_cyc + 2);
        check("tx3_data", tx_data, 8'h33);
        check("busy_idle", busy, 0);
        repeat (5) @(posedge clk); #1;
        check("tx_data_hold", tx_data, 8'h33);

        // Two back-to-back bytes: second buffered, written with no gap
        wr_cnt = 0;
        send_seq(2, 8'h3C, 8'h5A, 8'h00, 2);
        repeat (20) @(posedge clk); #1;
        check("b2b_writes", wr_cnt, 16);
        check("b2b_no_gap", last_wr_cyc, seq_cyc + 16);
        check("b2b_overrun", overrun, 0);

        // Three back-to-back bytes: the third is dropped
        wr_cnt = 0;
        send_seq(3, 8'h0F, 8'hF0, 8'h99, 2);
        repeat (20) @(posedge clk); #1;
        check("b3_writes", wr_cnt, 16);
        check("b3_overrun", overrun, 1);

        // Partial image, then reset
        for (int i = 0; i < 50; i++) begin
            send_seq(1, 8'(i * 7 + 1), 8'h00, 8'h00, 1);
            repeat (12) @(posedge clk);
        end
        #1;
        rst = 1'b1;
        check_en = 1'b0;
        exp_q.delete();
        pix = 0; exp_ovr = 1'b0; exp_cs = 1'b0;
        repeat (2) @(posedge clk); #1;
        check("rst_mid_overrun", overrun, 0);
        check("rst_mid_addr", ram_addr, 0);
        rst = 1'b0;
        check_en = 1'b1;
        wr_cnt = 0; cs_cnt = 0; first_addr = -1;
        for (int i = 0; i < 98; i++) begin
            if (i == 97) check("cs_before_last_byte", cs_cnt, 0);
            send_seq(1, 8'(i) ^ 8'h5A, 8'h00, 8'h00, 1);
            repeat (10) @(posedge clk);
        end
        #1;
        check("rst_first_addr", first_addr, 0);
        check("rst_img_writes", wr_cnt, 784);
        check("rst_img_cs_cnt", cs_cnt, 1);

        // Byte during WAIT_DONE is dropped; result still transmitted after tx_busy
        wr_before = wr_cnt;
        send_seq(1, 8'hEE, 8'h00, 8'h00, 0);
        repeat (12) @(posedge clk); #1;
        check("wait_rx_no_write", wr_cnt, wr_before);
        check("wait_rx_overrun", overrun, 1);
        tx_cnt = 0;
        do_done(4'd7, 10);
        repeat (6) @(posedge clk); #1;
        check("tx7_cnt", tx_cnt, 1);
        check("tx7_after_busy", tx_cyc, fall_cyc + 1);
        check("tx7_data", tx_data, 8'h37);

        // core_done outside WAIT_DONE is ignored
        tx_before = tx_cnt;
        @(posedge clk); #1;
        core_done = 1'b1; core_digit = 4'd5;
        @(posedge clk); #1;
        core_done = 1'b0;
        repeat (10) @(posedge clk); #1;
        check("idle_done_ignored", tx_cnt, tx_before);
        check("idle_busy", busy, 0);
        check("idle_tx_data", tx_data, 8'h37);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
